// File: rtl/cacheline_adapter_pkg.sv
// Shared widths and FSM state type for the cacheline adapter.
package cacheline_adapter_pkg;
  localparam int LINE_W      = 256;
  localparam int BEAT_W      = 64;
  localparam int BEATS       = LINE_W / BEAT_W;
  localparam int BEAT_IDX_W  = $clog2(BEATS);
  localparam int BEAT_SH     = $clog2(BEAT_W);
  localparam int LINE_IDX_W  = $clog2(LINE_W);
  localparam int OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_BEATS,
    WR_BEATS,
    RESP
  } adapter_state_t;
endpackage

// File: rtl/cacheline_adapter_beat_ctr.sv
// Beat index counter shared by the read-assembly and write-serialisation paths.
module adapter_beat_ctr
  import cacheline_adapter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  output logic [BEAT_IDX_W-1:0] count,
  output logic                  last_beat
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign last_beat = (count == BEAT_IDX_W'(BEATS - 1));

endmodule

// File: rtl/cacheline_adapter.sv
// One-line-at-a-time bridge from the cache dfp port to a 64-bit, 4-beat burst memory.
// Optional CACHELINE_ADAPTER_PERF_EN adds saturating read/write completion counters.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
`ifdef CACHELINE_ADAPTER_PERF_EN
  ,
  output logic [31:0]       perf_rd_cnt,
  output logic [31:0]       perf_wr_cnt
`endif
);

  adapter_state_t state, state_next;

  logic [31-OFFSET_BITS:0]       line_addr;
  logic [LINE_W-1:0]             wline;
  logic [LINE_W-BEAT_W-1:0]      rbuf;
  logic [BEAT_IDX_W-1:0]         beat_ctr;
  logic [LINE_IDX_W-1:0]         beat_base;
  logic                          last_beat;
  logic                          ctr_clr;
  logic                          ctr_inc;
  logic                          addr_offset_unused;

  assign addr_offset_unused = ^dfp_addr[OFFSET_BITS-1:0];

  adapter_beat_ctr u_beat_ctr (
    .clk       (clk),
    .rst       (rst),
    .clr       (ctr_clr),
    .inc       (ctr_inc),
    .count     (beat_ctr),
    .last_beat (last_beat)
  );

  assign beat_base = {beat_ctr, {BEAT_SH{1'b0}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ctr_clr    = 1'b0;
    ctr_inc    = 1'b0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    dfp_resp   = 1'b0;
    unique case (state)
      IDLE: begin
        ctr_clr = 1'b1;
        // Write has priority so a malformed read+write request still leaves memory consistent.
        if (dfp_write) begin
          state_next = WR_BEATS;
        end else if (dfp_read) begin
          state_next = RD_REQ;
        end
      end
      RD_REQ: begin
        bmem_read = 1'b1;
        if (bmem_ready) begin
          ctr_clr    = 1'b1;
          state_next = RD_BEATS;
        end
      end
      RD_BEATS: begin
        if (bmem_rvalid) begin
          ctr_inc = 1'b1;
          if (last_beat) begin
            state_next = RESP;
          end
        end
      end
      WR_BEATS: begin
        bmem_write = 1'b1;
        if (bmem_ready) begin
          ctr_inc = 1'b1;
          if (last_beat) begin
            state_next = RESP;
          end
        end
      end
      RESP: begin
        dfp_resp   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bmem_addr  = {line_addr, {OFFSET_BITS{1'b0}}};
  assign bmem_wdata = bmem_write ? wline[beat_base +: BEAT_W] : '0;

  // The last beat goes straight into dfp_rdata so the previous line stays visible until then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_addr <= '0;
      wline     <= '0;
      rbuf      <= '0;
      dfp_rdata <= '0;
    end else begin
      if (state == IDLE && (dfp_write || dfp_read)) begin
        line_addr <= dfp_addr[31:OFFSET_BITS];
      end
      if (state == IDLE && dfp_write) begin
        wline <= dfp_wdata;
      end
      if (state == RD_BEATS && bmem_rvalid) begin
        if (last_beat) begin
          dfp_rdata <= {bmem_rdata, rbuf};
        end else begin
          rbuf[beat_base +: BEAT_W] <= bmem_rdata;
        end
      end
    end
  end

`ifdef CACHELINE_ADAPTER_PERF_EN
  logic rd_op;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_op       <= 1'b0;
      perf_rd_cnt <= '0;
      perf_wr_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        rd_op <= dfp_read && !dfp_write;
      end
      if (state == RESP) begin
        if (rd_op && perf_rd_cnt != 32'hFFFF_FFFF) begin
          perf_rd_cnt <= perf_rd_cnt + 32'd1;
        end
        if (!rd_op && perf_wr_cnt != 32'hFFFF_FFFF) begin
          perf_wr_cnt <= perf_wr_cnt + 32'd1;
        end
      end
    end
  end
`endif

  assert property (@(posedge clk) disable iff (!rst)
                   !(state == IDLE && dfp_read && dfp_write))
    else $warning("cacheline_adapter: dfp_read and dfp_write both high, write serviced");

  assert property (@(posedge clk) disable iff (!rst)
                   !(bmem_rvalid && state != RD_BEATS))
    else $warning("cacheline_adapter: bmem_rvalid outside read burst ignored");

endmodule
